// File: rtl/step_conditioner.sv
// -----------------------------------------------------------------------------
// step_conditioner
//
// Turns a raw, bouncy, active-low pushbutton into a clean one-cycle "advance"
// strobe for the game-control FSM. It also provides the debounced button level
// and a running count of accepted presses.
//
// Ports
//   clk          rising-edge system clock
//   reset        asynchronous, active-high reset
//   key_n        raw asynchronous pushbutton, 0 = pressed
//   step         registered one-cycle pulse per accepted press
//   pressed      registered debounced level, 1 = held
//   press_count  registered modulo-2^CNT_W count of accepted presses
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable synchronized samples needed to accept
//                    a level change (1..255)
//   CNT_W            width of press_count
// -----------------------------------------------------------------------------
module step_conditioner #(
  parameter int DEBOUNCE_CYCLES = 2,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_n,
  output logic             step,
  output logic             pressed,
  output logic [CNT_W-1:0] press_count
);

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } state_t;

  // Counter value on which the debounce window is complete.
  localparam logic [7:0] LAST_CNT = 8'(DEBOUNCE_CYCLES - 1);

  // Two-flop synchronizer. Both stages reset to 1 (released) so a key held
  // down across reset is seen as a fresh falling edge afterwards.
  logic s1_reg;
  logic s2_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_reg <= 1'b1;
      s2_reg <= 1'b1;
    end else begin
      s1_reg <= key_n;
      s2_reg <= s1_reg;
    end
  end

  // FSM state and registered outputs.
  state_t           state_reg,   state_next;
  logic [7:0]       cnt_reg,     cnt_next;
  logic             step_reg,    step_next;
  logic             pressed_reg, pressed_next;
  logic [CNT_W-1:0] count_reg,   count_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= RELEASED;
      cnt_reg     <= 8'd0;
      step_reg    <= 1'b0;
      pressed_reg <= 1'b0;
      count_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      step_reg    <= step_next;
      pressed_reg <= pressed_next;
      count_reg   <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    step_next  = 1'b0;
    count_next = count_reg;

    case (state_reg)
      RELEASED: begin
        if (!s2_reg) begin
          state_next = PRESS_CHK;
          cnt_next   = 8'd0;
        end
      end

      PRESS_CHK: begin
        if (s2_reg) begin
          // Bounce back up before the window closed: discard silently.
          state_next = RELEASED;
        end else if (cnt_reg == LAST_CNT) begin
          // Press accepted: the strobe and the count move on the same edge.
          state_next = PRESSED;
          step_next  = 1'b1;
          count_next = count_reg + CNT_W'(1);
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end

      PRESSED: begin
        if (s2_reg) begin
          state_next = RELEASE_CHK;
          cnt_next   = 8'd0;
        end
      end

      RELEASE_CHK: begin
        if (!s2_reg) begin
          // Release bounce: return to PRESSED without another strobe.
          state_next = PRESSED;
        end else if (cnt_reg == LAST_CNT) begin
          state_next = RELEASED;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end

      default: begin
        state_next = RELEASED;
        cnt_next   = 8'd0;
      end
    endcase

    // Debounced level follows the state it is entering, so it is registered
    // alongside the state and changes on the same edge.
    pressed_next = (state_next == PRESSED) || (state_next == RELEASE_CHK);
  end

  assign step        = step_reg;
  assign pressed     = pressed_reg;
  assign press_count = count_reg;

endmodule

// File: tb/tb_step_conditioner.sv
// -----------------------------------------------------------------------------
// tb_step_conditioner
//
// Directed bench for step_conditioner with DEBOUNCE_CYCLES=2, CNT_W=8.
// key_n and reset change 1 time unit after a rising edge; outputs are sampled
// 1 time unit after each rising edge. Edge numbers count rising edges after
// key_n (or reset) last changed, so "edge 1" is the first edge sampling it.
// -----------------------------------------------------------------------------
module tb_step_conditioner;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       key_n = 1'b1;
  logic       step;
  logic       pressed;
  logic [7:0] press_count;

  int checks   = 0;
  int failures = 0;

  int  step_total;     // steps seen since last clear
  int  double_steps;   // step high on two consecutive samples
  logic prev_step;

  step_conditioner #(
    .DEBOUNCE_CYCLES(2),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key_n(key_n),
    .step(step),
    .pressed(pressed),
    .press_count(press_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] actual,
                           input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", tag, actual, expected, $time);
    end
  endtask

  // One rising edge, then sample point; tracks step pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    if (step === 1'b1) step_total++;
    if (step === 1'b1 && prev_step === 1'b1) double_steps++;
    prev_step = step;
  endtask

  task automatic clear_stats();
    step_total   = 0;
    double_steps = 0;
    prev_step    = 1'b0;
  endtask

  // Asynchronous reset pulse placed between edges; outputs must clear before
  // the next edge. Called 1 unit after an edge, returns before the next one.
  task automatic pulse_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    check_val({tag, "_step"},    32'(step),        32'd0);
    check_val({tag, "_pressed"}, 32'(pressed),     32'd0);
    check_val({tag, "_count"},   32'(press_count), 32'd0);
    reset = 1'b0;
    clear_stats();
  endtask

  // Hold key_n low for n_low edges, then high for n_high edges.
  task automatic press_release(input int n_low, input int n_high);
    key_n = 1'b0;
    repeat (n_low) tick();
    key_n = 1'b1;
    repeat (n_high) tick();
  endtask

  initial begin
    clear_stats();

    // ---------------- reset check ----------------
    #1 reset = 1'b1;
    #1;
    check_val("rst_async_step",    32'(step),        32'd0);
    check_val("rst_async_pressed", 32'(pressed),     32'd0);
    check_val("rst_async_count",   32'(press_count), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_val("idle_step",    32'(step),        32'd0);
      check_val("idle_pressed", 32'(pressed),     32'd0);
      check_val("idle_count",   32'(press_count), 32'd0);
    end
    $display("txn reset_idle done");

    // ---------------- clean press ----------------
    clear_stats();
    key_n = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      check_val($sformatf("clean_step_e%0d", e),    32'(step),        32'(e == 5));
      check_val($sformatf("clean_pressed_e%0d", e), 32'(pressed),     32'(e >= 5));
      check_val($sformatf("clean_count_e%0d", e),   32'(press_count), 32'(e >= 5));
    end
    key_n = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      check_val("clean_rel_step", 32'(step), 32'd0);
      if (e <= 3) check_val($sformatf("clean_rel_pressed_e%0d", e), 32'(pressed), 32'd1);
      if (e >= 5) check_val($sformatf("clean_rel_pressed_e%0d", e), 32'(pressed), 32'd0);
    end
    check_val("clean_total_steps", 32'(step_total), 32'd1);
    check_val("clean_final_count", 32'(press_count), 32'd1);
    $display("txn clean_press steps=%0d count=%0d", step_total, press_count);

    // Async reset with non-zero count must clear it between edges.
    pulse_reset("rst_after_clean");

    // ---------------- glitch boundary: 2 edges low ----------------
    press_release(2, 12);
    check_val("glitch2_steps", 32'(step_total), 32'd0);
    check_val("glitch2_count", 32'(press_count), 32'd0);
    check_val("glitch2_pressed", 32'(pressed), 32'd0);
    $display("txn glitch2 steps=%0d count=%0d", step_total, press_count);

    // ---------------- glitch boundary: 3 edges low ----------------
    clear_stats();
    key_n = 1'b0;
    for (int e = 1; e <= 3; e++) tick();
    key_n = 1'b1;
    tick();  // edge 4
    check_val("glitch3_step_e4", 32'(step), 32'd0);
    tick();  // edge 5
    check_val("glitch3_step_e5", 32'(step), 32'd1);
    repeat (10) tick();
    check_val("glitch3_steps", 32'(step_total), 32'd1);
    check_val("glitch3_count", 32'(press_count), 32'd1);
    check_val("glitch3_no_double", 32'(double_steps), 32'd0);
    $display("txn glitch3 steps=%0d count=%0d", step_total, press_count);

    // ---------------- release bounce ----------------
    pulse_reset("rst_before_bounce");
    key_n = 1'b0;
    repeat (8) tick();
    check_val("bounce_pressed_pre", 32'(pressed), 32'd1);
    check_val("bounce_count_pre", 32'(press_count), 32'd1);
    clear_stats();
    key_n = 1'b1; tick();
    key_n = 1'b0; tick();
    key_n = 1'b1; tick();
    key_n = 1'b0;
    for (int e = 0; e < 15; e++) begin
      tick();
      check_val("bounce_pressed_hold", 32'(pressed), 32'd1);
    end
    check_val("bounce_extra_steps", 32'(step_total), 32'd0);
    check_val("bounce_count_post", 32'(press_count), 32'd1);
    $display("txn release_bounce steps=%0d count=%0d", step_total, press_count);
    key_n = 1'b1;
    repeat (8) tick();

    // ---------------- wrap ----------------
    pulse_reset("rst_before_wrap");
    for (int i = 0; i < 256; i++) press_release(6, 8);
    check_val("wrap_steps_256", 32'(step_total), 32'd256);
    check_val("wrap_single_cycle", 32'(double_steps), 32'd0);
    check_val("wrap_count_256", 32'(press_count), 32'd0);
    $display("txn wrap256 steps=%0d count=%0d", step_total, press_count);
    press_release(6, 8);
    check_val("wrap_count_257", 32'(press_count), 32'd1);
    $display("txn wrap257 count=%0d", press_count);

    // ---------------- reset mid-press ----------------
    pulse_reset("rst_before_mid");
    key_n = 1'b0;
    repeat (7) tick();
    check_val("mid_pressed_pre", 32'(pressed), 32'd1);
    check_val("mid_count_pre", 32'(press_count), 32'd1);
    pulse_reset("rst_mid_press");   // key_n stays low across deassertion
    for (int e = 1; e <= 12; e++) begin
      tick();
      check_val($sformatf("mid_step_e%0d", e),    32'(step),    32'(e == 5));
      check_val($sformatf("mid_pressed_e%0d", e), 32'(pressed), 32'(e >= 5));
    end
    check_val("mid_steps", 32'(step_total), 32'd1);
    check_val("mid_count", 32'(press_count), 32'd1);
    $display("txn reset_mid_press steps=%0d count=%0d", step_total, press_count);

    // Reset in PRESS_CHK must abort without a step.
    key_n = 1'b1;
    repeat (8) tick();
    pulse_reset("rst_before_abort");
    key_n = 1'b0;
    repeat (4) tick();              // FSM now in PRESS_CHK
    key_n = 1'b1;
    pulse_reset("rst_in_press_chk");
    repeat (10) tick();
    check_val("abort_steps", 32'(step_total), 32'd0);
    check_val("abort_count", 32'(press_count), 32'd0);
    $display("txn reset_abort steps=%0d count=%0d", step_total, press_count);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog: the directed sequence is bounded, but never hang.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/step_conditioner.md
STEP_CONDITIONER -- requirements
Module: step_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 2, meaning consecutive stable synchronized samples needed to accept a level change; legal range 1..255.
REQ-002 SHALL have parameter CNT_W, default 8, meaning width of press_count.
REQ-003 clk  input  1  rising-edge system clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 key_n  input  1  raw, asynchronous, bouncy pushbutton; 0 = pressed.
REQ-006 step  output  1  registered one-cycle pulse per accepted press, consumed by the game-control FSM as its advance strobe.
REQ-007 pressed  output  1  registered debounced button level; 1 = held.
REQ-008 press_count  output  CNT_W  registered count of accepted presses.

Function
REQ-009 SHALL pass key_n through a two-flop synchronizer (s1, s2); s2 is the only key_n value used by the FSM.
REQ-010 SHALL implement FSM states RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK, plus a debounce counter of 8 bits.
REQ-011 RELEASED: s2=0 -> PRESS_CHK, counter cleared to 0; else stay.
REQ-012 PRESS_CHK: s2=1 -> RELEASED, no step; s2=0 and counter=DEBOUNCE_CYCLES-1 -> PRESSED; s2=0 otherwise -> counter+1, stay.
REQ-013 PRESSED: s2=1 -> RELEASE_CHK, counter cleared to 0; else stay.
REQ-014 RELEASE_CHK: s2=0 -> PRESSED, no step; s2=1 and counter=DEBOUNCE_CYCLES-1 -> RELEASED; s2=1 otherwise -> counter+1, stay.
REQ-015 step SHALL be 1 for exactly the one cycle following the PRESS_CHK->PRESSED edge, and 0 at all other times.
REQ-016 Latency: edge 1 is the first clk edge sampling key_n=0. step SHALL go high after edge DEBOUNCE_CYCLES+3, provided key_n stays 0 through edge DEBOUNCE_CYCLES+1.
REQ-017 A low pulse sampled on DEBOUNCE_CYCLES or fewer consecutive edges SHALL produce no step and no count change.
REQ-018 A bounce high while in PRESSED, or a bounce back low in RELEASE_CHK, SHALL never generate a second step.
REQ-019 A new step SHALL require a full return to RELEASED first.
REQ-020 pressed SHALL be 1 in PRESSED and RELEASE_CHK, and 0 in RELEASED and PRESS_CHK; it is registered and changes on the same edge as the state.
REQ-021 press_count SHALL increment on the same edge that raises step.
REQ-022 press_count SHALL be modulo 2^CNT_W, wrapping from all-ones to 0 with no flag.
REQ-023 All outputs SHALL be driven from flops only; there SHALL be no combinational path from key_n to any output.

Reset
REQ-024 reset=1 SHALL immediately, without waiting for clk, force:
- state = RELEASED;
- counter = 0;
- s1 = s2 = 1;
- step = 0;
- pressed = 0;
- press_count = 0.
REQ-025 Reset asserted mid-operation, in any state, SHALL abort that operation without emitting step.
REQ-026 If key_n is held 0 across reset deassertion, it SHALL count as a fresh press: exactly one step, at DEBOUNCE_CYCLES+3 edges after the first post-reset edge.
REQ-027 The first clk edge with reset=0 SHALL be treated as edge 1 for that latency count.

Verification (DEBOUNCE_CYCLES=2, CNT_W=8)
REQ-028 Reset check: key_n=1, pulse reset high between edges -> outputs go to 0 before the next edge; they hold step=0, pressed=0, press_count=0 for 10 idle cycles.
REQ-029 Clean press: key_n=0 for 10 edges, then 1 -> step high only after edge 5 (one cycle) and press_count=1. pressed is high from edge 5 and falls 5 edges after key_n returns to 1.
REQ-030 Glitch boundary: key_n=0 on exactly 2 edges -> no step and press_count=0; key_n=0 on exactly 3 edges -> one step and press_count=1.
REQ-031 Release bounce: in PRESSED, key_n pattern 1,0,1,0 for one edge each, then held 0 -> pressed stays 1, no extra step, press_count unchanged.
REQ-032 Wrap: 256 clean press/release cycles -> 256 single-cycle steps and press_count=0; after the 257th press, press_count=1.
REQ-033 Reset mid-press: assert reset in PRESSED with key_n held 0 -> outputs clear asynchronously; after deassertion, exactly one step after edge 5 and press_count=1.
